// File: rtl/btn_conditioner.sv
// Per-channel push-button conditioner: two-flop synchroniser, counter debounce,
// registered press/release edge pulses and a hold/auto-repeat pulse generator.
module btn_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  logic [N_BTN-1:0] sync1;
  logic [N_BTN-1:0] sync2;

  logic [CNT_W-1:0] dcnt      [N_BTN];
  logic [CNT_W-1:0] dcnt_nxt  [N_BTN];
  logic [CNT_W-1:0] hcnt      [N_BTN];
  logic [CNT_W-1:0] hcnt_nxt  [N_BTN];
  rpt_state_e       state     [N_BTN];
  rpt_state_e       state_nxt [N_BTN];

  logic [N_BTN-1:0] level_nxt;
  logic [N_BTN-1:0] press_nxt;
  logic [N_BTN-1:0] release_nxt;
  logic [N_BTN-1:0] repeat_nxt;

  // Next-state logic for debounce and the auto-repeat machine of every channel
  always_comb begin
    level_nxt   = btn_level;
    press_nxt   = '0;
    release_nxt = '0;
    repeat_nxt  = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_nxt[i]  = '0;
      hcnt_nxt[i]  = '0;
      state_nxt[i] = state[i];
    end

    for (int i = 0; i < N_BTN; i++) begin
      if (sync2[i] != btn_level[i]) begin
        if (dcnt[i] == DEB_LAST) begin
          level_nxt[i]   = ~btn_level[i];
          press_nxt[i]   = ~btn_level[i];
          release_nxt[i] = btn_level[i];
        end else begin
          dcnt_nxt[i] = dcnt[i] + CNT_ONE;
        end
      end

      // A debounced fall always wins over a terminal count, so no repeat
      // pulse can land in the release cycle.
      case (state[i])
        IDLE: begin
          if (press_nxt[i]) begin
            state_nxt[i] = HOLD;
          end
        end
        HOLD: begin
          if (release_nxt[i]) begin
            state_nxt[i] = IDLE;
          end else if (hcnt[i] == HOLD_LAST) begin
            repeat_nxt[i] = 1'b1;
            state_nxt[i]  = REPEAT;
          end else begin
            hcnt_nxt[i] = hcnt[i] + CNT_ONE;
          end
        end
        REPEAT: begin
          if (release_nxt[i]) begin
            state_nxt[i] = IDLE;
          end else if (hcnt[i] == RPT_LAST) begin
            repeat_nxt[i] = 1'b1;
          end else begin
            hcnt_nxt[i] = hcnt[i] + CNT_ONE;
          end
        end
        default: state_nxt[i] = IDLE;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_repeat  <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt[i]  <= '0;
        hcnt[i]  <= '0;
        state[i] <= IDLE;
      end
    end else begin
      sync1       <= btn_raw;
      sync2       <= sync1;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_repeat  <= repeat_nxt;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt[i]  <= dcnt_nxt[i];
        hcnt[i]  <= hcnt_nxt[i];
        state[i] <= state_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/hold/repeat periods;
// outputs are sampled 1 time unit after each rising clock edge.
module tb_btn_conditioner;

  localparam int unsigned N_BTN = 3;

  logic             clk;
  logic             rst;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_repeat;

  int checks = 0;
  int errors = 0;

  btn_conditioner #(
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (10),
    .REPEAT_CYCLES  (5),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .btn_repeat (btn_repeat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [N_BTN-1:0] lvl,
                     input logic [N_BTN-1:0] prs, input logic [N_BTN-1:0] rel,
                     input logic [N_BTN-1:0] rpt);
    checks++;
    assert (btn_level === lvl) else begin
      errors++;
      $error("FAIL %s level observed=%b expected=%b", tag, btn_level, lvl);
    end
    checks++;
    assert (btn_press === prs) else begin
      errors++;
      $error("FAIL %s press observed=%b expected=%b", tag, btn_press, prs);
    end
    checks++;
    assert (btn_release === rel) else begin
      errors++;
      $error("FAIL %s release observed=%b expected=%b", tag, btn_release, rel);
    end
    checks++;
    assert (btn_repeat === rpt) else begin
      errors++;
      $error("FAIL %s repeat observed=%b expected=%b", tag, btn_repeat, rpt);
    end
  endtask

  // Advance n cycles expecting a steady level and no pulses
  task automatic steady(input int n, input string tag, input logic [N_BTN-1:0] lvl);
    for (int c = 0; c < n; c++) begin
      tick();
      chk(tag, lvl, '0, '0, '0);
    end
  endtask

  initial begin
    logic [7:0] bounce;
    logic [N_BTN-1:0] rpt_exp;

    rst     = 1'b1;
    btn_raw = '0;
    tick();
    tick();
    chk("reset", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;

    // Clean press on channel 0: level flips after the 6th edge
    btn_raw = 3'b001;
    steady(5, "press0_wait", 3'b000);
    tick();
    chk("press0", 3'b001, 3'b001, 3'b000, 3'b000);
    btn_raw = 3'b000;
    steady(5, "press0_held", 3'b001);
    tick();
    chk("release0", 3'b000, 3'b000, 3'b001, 3'b000);
    steady(2, "idle0", 3'b000);

    // Bounce rejection on channel 1: 3-cycle highs never qualify
    bounce = 8'b0111_0111;
    for (int k = 0; k < 8; k++) begin
      btn_raw = {1'b0, bounce[7-k], 1'b0};
      tick();
      chk("bounce1", 3'b000, 3'b000, 3'b000, 3'b000);
    end
    btn_raw = 3'b000;
    steady(4, "bounce1_drain", 3'b000);
    btn_raw = 3'b010;
    steady(5, "press1_wait", 3'b000);
    tick();
    chk("press1", 3'b010, 3'b010, 3'b000, 3'b000);
    btn_raw = 3'b000;
    steady(5, "press1_held", 3'b010);
    tick();
    chk("release1", 3'b000, 3'b000, 3'b010, 3'b000);
    steady(2, "idle1", 3'b000);

    // Auto-repeat on channel 2: repeats at press+10,+15,...,+35; fall at +40
    btn_raw = 3'b100;
    steady(5, "press2_wait", 3'b000);
    tick();
    chk("press2", 3'b100, 3'b100, 3'b000, 3'b000);
    for (int k = 1; k <= 39; k++) begin
      if (k >= 35) btn_raw = 3'b000;
      tick();
      rpt_exp = (k >= 10 && (k - 10) % 5 == 0) ? 3'b100 : 3'b000;
      chk("repeat2", 3'b100, 3'b000, 3'b000, rpt_exp);
    end
    tick();
    chk("release2", 3'b000, 3'b000, 3'b100, 3'b000);
    steady(8, "idle2", 3'b000);

    // Simultaneous press and release on all channels
    btn_raw = 3'b111;
    steady(5, "press_all_wait", 3'b000);
    tick();
    chk("press_all", 3'b111, 3'b111, 3'b000, 3'b000);
    btn_raw = 3'b000;
    steady(5, "held_all", 3'b111);
    tick();
    chk("release_all", 3'b000, 3'b000, 3'b111, 3'b000);
    steady(2, "idle_all", 3'b000);

    // Reset while channel 0 is in REPEAT
    btn_raw = 3'b001;
    steady(5, "press0b_wait", 3'b000);
    tick();
    chk("press0b", 3'b001, 3'b001, 3'b000, 3'b000);
    for (int k = 1; k <= 12; k++) begin
      tick();
      rpt_exp = (k == 10) ? 3'b001 : 3'b000;
      chk("repeat0b", 3'b001, 3'b000, 3'b000, rpt_exp);
    end
    rst = 1'b1;
    tick();
    chk("rst_mid1", 3'b000, 3'b000, 3'b000, 3'b000);
    tick();
    chk("rst_mid2", 3'b000, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    steady(5, "requal0", 3'b000);
    tick();
    chk("press0c", 3'b001, 3'b001, 3'b000, 3'b000);

    // Short release glitch while held: no release, repeat cadence unchanged
    for (int k = 1; k <= 31; k++) begin
      btn_raw = ((k >= 3 && k <= 5) || k >= 27) ? 3'b000 : 3'b001;
      tick();
      rpt_exp = (k >= 10 && (k - 10) % 5 == 0) ? 3'b001 : 3'b000;
      chk("glitch0", 3'b001, 3'b000, 3'b000, rpt_exp);
    end
    tick();
    chk("release0c", 3'b000, 3'b000, 3'b001, 3'b000);
    steady(3, "idle_end", 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Sits directly upstream of the colour Decoder, between the raw board push-buttons and the Decoder's btn inputs.
- Takes asynchronous, bouncing pushbutton inputs and synchronises and debounces each one.
- Produces clean single-cycle press, release and auto-repeat pulses, plus a stable debounced level.
- The Decoder consumes btn_press and btn_repeat, so that holding a button steps brightness at a controlled rate.

Parameters:
- N_BTN, 3: number of independent button channels.
- DEBOUNCE_CYCLES, 1000000: consecutive clk cycles the synchronised input must differ from the stable level before the level flips (10 ms at 100 MHz).
- HOLD_CYCLES, 50000000: cycles from press to the first repeat pulse.
- REPEAT_CYCLES, 10000000: cycles between subsequent repeat pulses.
- CNT_W, 26: counter width. Must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  N_BTN  raw, asynchronous, bouncing button inputs (1 = pressed).
- btn_level  output  N_BTN  debounced stable level.
- btn_press  output  N_BTN  one-cycle pulse on a debounced 0->1 transition.
- btn_release  output  N_BTN  one-cycle pulse on a debounced 1->0 transition.
- btn_repeat  output  N_BTN  one-cycle auto-repeat pulses while the button is held.

Behaviour:
- Reset and clocking
  - Single clock domain (clk); reset is synchronous and active-high (rst). Both are fixed.
  - On rst=1 at a clk edge, clear all of the following to 0: synchroniser flops, debounce counters, hold counters, repeat-phase flags, btn_level, btn_press, btn_release, btn_repeat.
- Channel independence
  - Each channel is fully independent; no arbitration between channels.
  - Simultaneous events on different channels all appear in the same cycle.
- Synchroniser
  - Two-flop synchroniser per bit: sync1 <= btn_raw, sync2 <= sync1.
  - All further logic uses sync2 only.
- Debounce (per channel)
  - mismatch = (sync2 != btn_level).
  - If mismatch=0: dcnt <= 0.
  - If mismatch=1 and dcnt == DEBOUNCE_CYCLES-1: btn_level <= ~btn_level and dcnt <= 0.
  - Otherwise, if mismatch=1: dcnt <= dcnt+1.
  - Any single-cycle return to a match restarts the count; glitches shorter than DEBOUNCE_CYCLES never change btn_level.
  - Latency: if btn_raw is high from the edge E1 onward, btn_level is 1 after edge E(DEBOUNCE_CYCLES+2). The same holds for release.
- Edge pulses
  - btn_press and btn_release are registered.
  - Each asserts for exactly one cycle, in the same cycle btn_level changes.
  - They are never asserted together on one channel.
- Auto-repeat state machine (per channel), states IDLE, HOLD, REPEAT:
  - IDLE: hcnt=0. On a debounced rise, go to HOLD with hcnt <= 0.
  - HOLD: hcnt increments each cycle while btn_level=1. When hcnt == HOLD_CYCLES-1, pulse btn_repeat, set hcnt <= 0 and go to REPEAT.
  - REPEAT: hcnt increments each cycle. When hcnt == REPEAT_CYCLES-1, pulse btn_repeat and set hcnt <= 0.
  - HOLD or REPEAT with a debounced fall: go to IDLE, hcnt <= 0. No btn_repeat in the btn_release cycle.
  - First btn_repeat comes HOLD_CYCLES cycles after btn_press; later ones every REPEAT_CYCLES cycles.
- Reset mid-operation
  - Outputs are cleared even if the button is physically held.
  - After rst deasserts, a held button re-qualifies through full debounce and produces a fresh btn_press.
- Counters never wrap: each one is bounded by its terminal compare before overflow.

Test Plan (bench parameters: N_BTN=3, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5):
- Clean press: btn_raw[0] 0->1 before edge E1, then held. Required: btn_level[0]=1 and a single btn_press[0] pulse after E6; channels 1 and 2 stay 0.
- Bounce rejection: btn_raw[1] toggles 1,1,1,0,1,1,1,0 (3-cycle runs). Required: btn_level[1] stays 0 and no pulses. Then hold high for 6 cycles: exactly one btn_press[1].
- Auto-repeat: hold btn_raw[2] for 40 cycles after its btn_press. Required: btn_repeat[2] at press+10, +15, +20, +25, +30, +35 cycles. Release: one btn_release[2], no further btn_repeat, state returns to IDLE.
- Simultaneous: btn_raw=3'b111 on one edge. Required: all three btn_press bits pulse in the same cycle. Release all: all three btn_release bits pulse together.
- Reset mid-hold: rst=1 for 2 cycles while btn_raw[0]=1 and in REPEAT. Required: all outputs 0 during and after reset, no btn_repeat. btn_press[0] re-asserts 6 cycles after rst deasserts.
- Short release glitch: while btn_level[0]=1, drop btn_raw[0] for 3 cycles. Required: no btn_release[0], and the repeat cadence is unaffected.
